// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit arbiter.
//   - arb_state_e : 2-bit FSM encoding (ARB_IDLE/ARB_LAUNCH/ARB_WAIT/ARB_HOLD)
//   - UART_DW     : serializer data width (8)
//   - rr_pick()   : round-robin search over up to RR_MAX request lines,
//                   returning the winning index and a found flag
package uart_pkg;

   localparam int UART_DW = 8;
   localparam int RR_MAX  = 8;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_LAUNCH = 2'd1,
      ARB_WAIT   = 2'd2,
      ARB_HOLD   = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_res_t;

   // First set bit of valid at or after ptr, wrapping modulo n.
   // The loop runs from the farthest offset down so the nearest candidate
   // is written last and wins without needing an early exit.
   function automatic rr_res_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input logic [2:0]        ptr,
                                       input int                n);
      rr_res_t res;
      int      cand;
      res = '0;
      for (int k = RR_MAX - 1; k >= 0; k--) begin
         if (k < n) begin
            cand = (int'(ptr) + k) % n;
            if (valid[cand]) begin
               res.found = 1'b1;
               res.idx   = 3'(cand);
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_pick_n.sv
// rr_pick_n: combinational round-robin priority encoder.
//   valid : request lines, one per requester
//   ptr   : index with top priority this cycle
//   idx   : winning requester (meaningful only when found=1)
//   found : at least one request line is set
import uart_pkg::*;

module rr_pick_n #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         valid,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     found
);

   localparam int IDW = $clog2(N_REQ);

   rr_res_t res;

   always_comb begin
      res   = rr_pick(RR_MAX'(valid), 3'(ptr), N_REQ);
      idx   = IDW'(res.idx);
      found = res.found;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer among N_REQ byte sources.
// Round-robin between messages; the winner keeps the serializer until it
// sends a byte marked last, or until it stays silent for HOLD_TO cycles.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/data/last   : per-requester byte offer (data at [8i+7:8i])
//   req_ready             : one-hot accept, high only in the accept cycle
//   tx_start, tx_din      : to uart_tx start/din
//   tx_rdy                : from uart_tx, high when the serializer is idle
//   grant_id              : current or most recent owner
//   busy                  : FSM is outside IDLE
import uart_pkg::*;

module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int HOLD_TO = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [UART_DW*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]           req_last,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       tx_start,
   output logic [UART_DW-1:0]         tx_din,
   input  logic                       tx_rdy,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy
);

   localparam int IDW = $clog2(N_REQ);
   localparam int CW  = (HOLD_TO > 0) ? $clog2(HOLD_TO + 1) : 1;

   arb_state_e         state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [IDW-1:0]     grant_q, grant_d;
   logic [UART_DW-1:0] din_q, din_d;
   logic               last_q, last_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic [IDW-1:0]     pick_idx;
   logic               pick_found;
   logic [IDW-1:0]     next_ptr;
   logic [IDW-1:0]     sel_idx;
   logic               take;

   rr_pick_n #(.N_REQ(N_REQ)) u_pick (
      .valid (req_valid),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Priority moves to the requester after the owner once it lets go.
   assign next_ptr = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + IDW'(1);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      din_d     = din_q;
      last_d    = last_q;
      cnt_d     = '0;
      req_ready = '0;
      tx_start  = 1'b0;
      take      = 1'b0;
      sel_idx   = pick_idx;

      case (state_q)
         ARB_IDLE: begin
            take = tx_rdy & pick_found;
         end
         ARB_LAUNCH: begin
            // start is held until uart_tx acknowledges by dropping rdy
            if (tx_rdy) tx_start = 1'b1;
            else        state_d  = ARB_WAIT;
         end
         ARB_WAIT: begin
            if (tx_rdy) begin
               if (last_q) begin
                  ptr_d   = next_ptr;
                  state_d = ARB_IDLE;
               end else begin
                  state_d = ARB_HOLD;
               end
            end
         end
         ARB_HOLD: begin
            // Only the owner may continue; everyone else waits for IDLE.
            sel_idx = grant_q;
            if (tx_rdy && req_valid[grant_q]) begin
               take = 1'b1;
            end else if (HOLD_TO > 0 && cnt_q == CW'(HOLD_TO)) begin
               ptr_d   = next_ptr;
               state_d = ARB_IDLE;
            end else if (cnt_q != CW'(HOLD_TO)) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      if (take) begin
         req_ready[sel_idx] = 1'b1;
         din_d   = req_data[int'(sel_idx)*UART_DW +: UART_DW];
         last_d  = req_last[sel_idx];
         grant_d = sel_idx;
         state_d = ARB_LAUNCH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         din_q   <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         din_q   <= din_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign tx_din   = din_q;
   assign grant_id = grant_q;
   assign busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int HT    = 16;
   localparam int FRAME = 10;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [8*N-1:0]   req_data = '0;
   logic [N-1:0]     req_last = '0;
   logic [N-1:0]     req_ready;
   logic             tx_start;
   logic [7:0]       tx_din;
   logic             tx_rdy;
   logic [1:0]       grant_id;
   logic             busy;

   logic             m_rdy = 1'b1;
   int               m_cnt = 0;
   logic             force_busy = 1'b0;

   assign tx_rdy = m_rdy & ~force_busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .HOLD_TO(HT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_start  (tx_start),
      .tx_din    (tx_din),
      .tx_rdy    (tx_rdy),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   // uart_tx stand-in: no reset, rdy drops the cycle after start, frame of FRAME+1 cycles
   always @(posedge clk) begin
      if (tx_start && tx_rdy) begin
         m_rdy <= 1'b0;
         m_cnt <= FRAME;
      end else if (!m_rdy) begin
         if (m_cnt == 0) m_rdy <= 1'b1;
         else            m_cnt <= m_cnt - 1;
      end
   end

   logic [7:0] tx_log[$];
   int         gid_log[$];
   int         acc_log[$];
   int         start_hi = 0;
   int         viol = 0;

   always @(posedge clk) begin
      if (tx_start) start_hi <= start_hi + 1;
      if (tx_start && tx_rdy) begin
         tx_log.push_back(tx_din);
         gid_log.push_back(int'(grant_id));
      end
      for (int i = 0; i < N; i++)
         if (req_valid[i] && req_ready[i]) acc_log.push_back(i);
      if ($countones(req_ready) > 1) viol <= viol + 1;
   end

   function automatic int tx_at(input int i);
      if (i < tx_log.size()) return int'(tx_log[i]);
      return -1;
   endfunction
   function automatic int gid_at(input int i);
      if (i < gid_log.size()) return gid_log[i];
      return -1;
   endfunction
   function automatic int acc_at(input int i);
      if (i < acc_log.size()) return acc_log[i];
      return -1;
   endfunction

   // requester agents: each holds one message; bit 8 of a word is 'last'
   logic [8:0]   mem [N][4];
   int           len [N];
   int           pos [N];
   logic [N-1:0] en = '0;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_msg(input int s, input int l, input logic [8:0] b0,
                          input logic [8:0] b1, input logic [8:0] b2, input logic [8:0] b3);
      mem[s][0] = b0; mem[s][1] = b1; mem[s][2] = b2; mem[s][3] = b3;
      len[s] = l;
      pos[s] = 0;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = en[i] && (pos[i] < len[i]);
         if (pos[i] < len[i]) begin
            req_data[8*i +: 8] = mem[i][pos[i]][7:0];
            req_last[i]        = mem[i][pos[i]][8];
         end
      end
   endtask

   task automatic step();
      logic [N-1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) pos[i]++;
      drive();
   endtask

   task automatic wait_tx(input string tag, input int target);
      int k = 0;
      while (tx_log.size() < target && k < 500) begin step(); k++; end
      chk({tag, "_tx_to"}, 32'(tx_log.size() >= target), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((busy || !tx_rdy) && k < 500) begin step(); k++; end
      chk({tag, "_idle_to"}, 32'(!busy && tx_rdy), 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got=running want=finished");
      $fatal(1);
   end

   initial begin
      int b_s, b_tx, b_acc, n, k, early;
      int exp_b[5];
      int exp_g[5];
      int exp_a[5];
      for (int i = 0; i < N; i++) begin len[i] = 0; pos[i] = 0; end

      // reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_din", tx_din, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      step();

      // single-byte message
      set_msg(0, 1, 9'h141, 9'h0, 9'h0, 9'h0);
      en = 4'b0001;
      drive();
      #1;
      chk("t1_ready", req_ready, 4'b0001);
      b_s = start_hi; b_tx = tx_log.size(); b_acc = acc_log.size();
      step();
      chk("t1_start", tx_start, 1);
      chk("t1_din", tx_din, 8'h41);
      chk("t1_busy", busy, 1);
      chk("t1_ready_drop", req_ready, 0);
      chk("t1_gid", grant_id, 0);
      wait_idle("t1");
      chk("t1_start_cycles", start_hi - b_s, 1);
      chk("t1_acc_cnt", acc_log.size() - b_acc, 1);
      chk("t1_tx", tx_at(b_tx), 8'h41);
      chk("t1_din_hold", tx_din, 8'h41);
      // ptr now 1: req1 beats req0; then both withdraw before accept
      set_msg(0, 1, 9'h141, 9'h0, 9'h0, 9'h0);
      set_msg(1, 1, 9'h142, 9'h0, 9'h0, 9'h0);
      en = 4'b0011;
      drive();
      #1;
      chk("t1_ptr", req_ready, 4'b0010);
      en = 4'b0000;
      drive();
      #1;
      chk("t1_withdraw_rdy", req_ready, 0);
      repeat (3) step();
      chk("t1_withdraw_busy", busy, 0);
      chk("t1_withdraw_acc", acc_log.size() - b_acc, 1);

      // round-robin after reset
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      set_msg(0, 2, 9'h141, 9'h141, 9'h0, 9'h0);
      set_msg(1, 1, 9'h142, 9'h0, 9'h0, 9'h0);
      set_msg(2, 1, 9'h143, 9'h0, 9'h0, 9'h0);
      set_msg(3, 1, 9'h144, 9'h0, 9'h0, 9'h0);
      en = 4'b1111;
      b_tx = tx_log.size();
      drive();
      wait_tx("t2", b_tx + 5);
      exp_b = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
      exp_g = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t2_byte%0d", i), tx_at(b_tx + i), exp_b[i]);
         chk($sformatf("t2_gid%0d", i), gid_at(b_tx + i), exp_g[i]);
      end
      wait_idle("t2");

      // message lock: req1 "ab\r\n" while req2 waits (ptr is 1)
      set_msg(1, 4, 9'h061, 9'h062, 9'h00d, 9'h10a);
      set_msg(2, 1, 9'h158, 9'h0, 9'h0, 9'h0);
      en = 4'b0110;
      b_tx = tx_log.size(); b_acc = acc_log.size();
      drive();
      wait_tx("t3", b_tx + 5);
      exp_b = '{8'h61, 8'h62, 8'h0d, 8'h0a, 8'h58};
      exp_a = '{1, 1, 1, 1, 2};
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t3_byte%0d", i), tx_at(b_tx + i), exp_b[i]);
         chk($sformatf("t3_acc%0d", i), acc_at(b_acc + i), exp_a[i]);
      end
      wait_idle("t3");

      // hold timeout (ptr is 3 here, req0 is the only one asking at first)
      set_msg(0, 1, 9'h031, 9'h0, 9'h0, 9'h0);
      en = 4'b0001;
      b_tx = tx_log.size(); b_acc = acc_log.size();
      drive();
      k = 0;
      while (acc_log.size() == b_acc && k < 50) begin step(); k++; end
      chk("t4_acc0", acc_at(b_acc), 0);
      set_msg(3, 1, 9'h144, 9'h0, 9'h0, 9'h0);
      en = 4'b1001;
      drive();
      n = 0; k = 0;
      do begin
         step(); k++;
         if (busy && tx_rdy && !tx_start) n++;
      end while (busy && k < 200);
      // 1 WAIT cycle + 17 HOLD cycles (counter 0..16, leaves when it reads 16)
      chk("t4_hold_cycles", n, 18);
      chk("t4_ready", req_ready, 4'b1000);
      wait_tx("t4", b_tx + 2);
      chk("t4_byte0", tx_at(b_tx), 8'h31);
      chk("t4_byte1", tx_at(b_tx + 1), 8'h44);
      chk("t4_gid1", gid_at(b_tx + 1), 3);
      chk("t4_grant", grant_id, 3);
      wait_idle("t4");

      // reset during WAIT
      set_msg(1, 1, 9'h151, 9'h0, 9'h0, 9'h0);
      en = 4'b0010;
      drive();
      k = 0;
      while (!(busy && !tx_rdy) && k < 50) begin step(); k++; end
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_start", tx_start, 0);
      chk("t5_rst_din", tx_din, 0);
      chk("t5_rst_ready", req_ready, 0);
      chk("t5_rst_grant", grant_id, 0);
      chk("t5_rst_busy", busy, 0);
      step(); step();
      rst_n = 1'b1;
      chk("t5_model_busy", tx_rdy, 0);
      set_msg(0, 1, 9'h130, 9'h0, 9'h0, 9'h0);
      set_msg(1, 1, 9'h151, 9'h0, 9'h0, 9'h0);
      en = 4'b0011;
      drive();
      #1;
      b_tx = tx_log.size(); b_acc = acc_log.size();
      early = 0; k = 0;
      while (!tx_rdy && k < 50) begin
         if (req_ready != 0) early++;
         step(); k++;
      end
      chk("t5_early_ready", early, 0);
      chk("t5_first_ready", req_ready, 4'b0001);
      step();
      chk("t5_first_acc", acc_at(b_acc), 0);
      wait_tx("t5", b_tx + 2);
      chk("t5_byte0", tx_at(b_tx), 8'h30);
      chk("t5_byte1", tx_at(b_tx + 1), 8'h51);
      wait_idle("t5");

      // serializer busy across reset for 50 cycles
      rst_n = 1'b0;
      force_busy = 1'b1;
      step();
      rst_n = 1'b1;
      set_msg(2, 1, 9'h132, 9'h0, 9'h0, 9'h0);
      en = 4'b0100;
      drive();
      #1;
      b_acc = acc_log.size();
      early = 0;
      repeat (50) begin
         if (req_ready != 0) early++;
         step();
      end
      chk("t6_early_ready", early, 0);
      chk("t6_no_acc", acc_log.size() - b_acc, 0);
      force_busy = 1'b0;
      #1;
      chk("t6_ready", req_ready, 4'b0100);
      step();
      chk("t6_acc", acc_at(b_acc), 2);
      chk("t6_start", tx_start, 1);
      wait_idle("t6");

      chk("onehot_ready", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` serializer among `N_REQ` byte sources. Round-robin arbitration, with message locking: once a source wins, it keeps the transmitter until it sends a byte marked `last`, so lines from different sources never interleave. The block sits between the message producers (status reporters, debug printers) and `uart_tx`. It replaces hand-written per-source sequencers with the START/WAIT/NEXT handshake against `tx_rdy`.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters, 2..8.
- `HOLD_TO`, 1024 — max idle cycles a locked requester may hold the transmitter between bytes; 0 disables the timeout.

Ports:
- `clk` in 1 — single clock. All logic is on its rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req_valid` in N_REQ — requester i presents a byte.
- `req_data` in 8*N_REQ — byte of requester i at bits [8i+7:8i].
- `req_last` in N_REQ — byte is the final byte of its message.
- `req_ready` out N_REQ — one-hot accept. A byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_start` out 1 — to `uart_tx.start`.
- `tx_din` out 8 — to `uart_tx.din`.
- `tx_rdy` in 1 — from `uart_tx.rdy`; high means the serializer is idle.
- `grant_id` out $clog2(N_REQ) — current or last owner.
- `busy` out 1 — high in any state other than IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT, HOLD.
- **IDLE**
  - When `tx_rdy=1` and any `req_valid`, pick the first valid index at or after `ptr`, wrapping modulo N_REQ.
  - In the same cycle: assert `req_ready[i]`, latch the byte into `din_q` and `req_last[i]` into `last_q`, set `grant_id=i`, go to LAUNCH.
- **LAUNCH**
  - `tx_start=1` and `tx_din=din_q` while `tx_rdy=1`.
  - When `tx_rdy=0`, drop `tx_start` and go to WAIT.
- **WAIT**
  - When `tx_rdy=1`:
    - if `last_q=1`: set `ptr=grant_id+1` (wrapping) and go to IDLE;
    - otherwise go to HOLD and clear the timeout counter.
- **HOLD**
  - Only `req_valid[grant_id]` is considered. When it is high and `tx_rdy=1`, accept exactly as in IDLE and go to LAUNCH.
  - Other requesters are never granted in HOLD.
  - Timeout: if `HOLD_TO>0` and the counter reaches `HOLD_TO` with no valid from the owner, set `ptr=grant_id+1` and go to IDLE. The message is abandoned; no byte is dropped.
- `tx_din` is held at `din_q` at all times, so it is stable through serialization.
- At most one bit of `req_ready` is ever high.
- `req_ready` is high only in IDLE/HOLD cycles in which a byte is taken.

## Timing
- Reset values:
  - state IDLE, `ptr=0`, `din_q=0`, `last_q=0`, timeout counter 0;
  - `tx_start=0`, `tx_din=0`, `req_ready=0`, `grant_id=0`, `busy=0`.
- Accept-to-start latency: byte accepted in cycle t, `tx_start=1` from t+1.
- `tx_start` stays high until the first cycle `tx_rdy` is seen low. It is never high while the FSM is in WAIT, HOLD or IDLE.
- Back-to-back bytes of one message: after `tx_rdy` rises in WAIT, the next accept happens in HOLD no earlier than the cycle after. That gives a minimum 1-cycle idle gap at `tx_rdy`.
- Simultaneous requests in IDLE: round-robin from `ptr`. After reset, requester 0 has top priority.
- Valid withdrawn before accept: legal and ignored. A requester must hold `req_data`/`req_last` stable only in the accept cycle.
- `tx_rdy=0` in IDLE (serializer still busy, e.g. a byte in flight across `rst_n`): no grant until `tx_rdy=1`. `uart_tx` has no reset and finishes its frame on its own.
- Reset mid-operation: all state returns to reset values immediately (async). A partially sent message is abandoned; the requester restarts it.
- Timeout counter width is $clog2(HOLD_TO+1). It counts only in HOLD, saturates, and clears on leaving HOLD.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants `ARB_IDLE`/`ARB_LAUNCH`/`ARB_WAIT`/`ARB_HOLD`, 2 bits;
  - `UART_DW=8`;
  - helper function `rr_pick(valid, ptr)` returning index and found flag.
- One sub-module, `rr_pick_n`: combinational round-robin priority encoder, parameterised by N_REQ, used in IDLE.
- Top: FSM, `din_q`/`last_q`/`ptr` registers, timeout counter.

## Test plan
- **Single-byte message:** req0 sends 0x41 with `last=1`, model `uart_tx` drops `tx_rdy` 1 cycle after start → `req_ready[0]` pulses once, `tx_start` high exactly 1 cycle, `tx_din=0x41` through the frame, FSM returns to IDLE, `ptr=1`.
- **Round-robin:** req0..3 all valid, each with 1-byte messages "A","B","C","D" → transmit order A,B,C,D, then A again. `grant_id` sequence 0,1,2,3,0.
- **Message lock:** req1 sends "ab\r\n" (`last` on `\n`) while req2 is valid throughout → all 4 bytes of req1 go out before any req2 byte; `req_ready[2]` stays 0 until req1's `\n` completes.
- **Hold timeout:** `HOLD_TO=16`; req0 sends 0x31 with `last=0` then goes silent, req3 valid → after 16 HOLD cycles FSM goes to IDLE, req3 granted next, `grant_id=3`.
- **Reset during WAIT:** pulse `rst_n` low while the model is mid-frame with `tx_rdy=0` → outputs go to reset values asynchronously; no grant until model `tx_rdy=1`, then req0 is granted first.
- **Busy serializer at reset:** `tx_rdy=0` held for 50 cycles after reset, req2 valid → `req_ready` stays 0 for those 50 cycles and is accepted in the first cycle `tx_rdy=1`.
